// File: rtl/bottling_core_mf.sv
// Pill bottling core: counts feeder pulses into bottles against settings latched
// at start, with pause/resume, abort, jam watchdog and overflow (spill) accounting.
module bottling_core_mf #(
    parameter int NUM_FEEDERS = 2,
    parameter int CNT_W       = 8,
    parameter int TOTAL_W     = 16,
    parameter int JAM_CYCLES  = 1000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   display_flicker,
    input  logic [NUM_FEEDERS-1:0] pill_pulse,
    input  logic                   flip_working,
    input  logic                   abort,
    input  logic [CNT_W-1:0]       bottle_setting,
    input  logic [CNT_W-1:0]       pill_setting,
    output logic [CNT_W-1:0]       pill_current,
    output logic [CNT_W-1:0]       bottle_current,
    output logic [TOTAL_W-1:0]     total_current,
    output logic [CNT_W-1:0]       spill_count,
    output logic [2:0]             state,
    output logic                   working,
    output logic                   finished,
    output logic                   jam,
    output logic                   beep
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_JAM   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int N_W  = $clog2(NUM_FEEDERS + 1);
    localparam int E_W  = CNT_W + 1;
    localparam int WD_W = (JAM_CYCLES > 2) ? $clog2(JAM_CYCLES) : 1;
    localparam bit WD_EN = (JAM_CYCLES > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((JAM_CYCLES > 0) ? JAM_CYCLES - 1 : 0);

    function automatic logic [N_W-1:0] popcount(input logic [NUM_FEEDERS-1:0] v);
        logic [N_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_FEEDERS; i++) begin
            s = s + N_W'(v[i]);
        end
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [E_W-1:0]   b);
        logic [CNT_W+1:0] s;
        s = (CNT_W + 2)'(a) + (CNT_W + 2)'(b);
        if (|s[CNT_W+1:CNT_W]) begin
            return '1;
        end
        return s[CNT_W-1:0];
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   pill_q, pill_d;
    logic [CNT_W-1:0]   bottle_q, bottle_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [CNT_W-1:0]   spill_q, spill_d;
    logic [CNT_W-1:0]   pset_q, pset_d;
    logic [CNT_W-1:0]   bset_q, bset_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    logic [E_W-1:0]     n_ext;
    logic [E_W-1:0]     rem;
    logic               complete;
    logic [CNT_W-1:0]   bottle_inc;

    assign n_ext      = E_W'(popcount(pill_pulse));
    assign rem        = {1'b0, pset_q} - {1'b0, pill_q};
    assign complete   = (n_ext != '0) && (n_ext >= rem);
    assign bottle_inc = bottle_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        pill_d   = pill_q;
        bottle_d = bottle_q;
        total_d  = total_q;
        spill_d  = spill_q;
        pset_d   = pset_q;
        bset_d   = bset_q;
        wd_d     = wd_q;
        if (abort) begin
            state_d  = S_IDLE;
            pill_d   = '0;
            bottle_d = '0;
            total_d  = '0;
            spill_d  = '0;
            wd_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (flip_working && (bottle_setting != '0) && (pill_setting != '0)) begin
                        state_d  = S_RUN;
                        pset_d   = pill_setting;
                        bset_d   = bottle_setting;
                        pill_d   = '0;
                        bottle_d = '0;
                        total_d  = '0;
                        spill_d  = '0;
                        wd_d     = '0;
                    end
                end
                S_RUN: begin
                    if (n_ext != '0) begin
                        wd_d = '0;
                        if (complete) begin
                            // Excess pulses beyond the bottle are spilled, never carried over.
                            pill_d   = '0;
                            bottle_d = bottle_inc;
                            total_d  = total_q + TOTAL_W'(rem);
                            spill_d  = sat_add(spill_q, n_ext - rem);
                        end else begin
                            pill_d  = pill_q + CNT_W'(n_ext);
                            total_d = total_q + TOTAL_W'(n_ext);
                        end
                    end
                    if (complete && (bottle_inc == bset_q)) begin
                        state_d = S_DONE;
                    end else if (flip_working) begin
                        state_d = S_PAUSE;
                    end else if (WD_EN && (n_ext == '0)) begin
                        if (wd_q == WD_LAST) begin
                            state_d = S_JAM;
                        end else begin
                            wd_d = wd_q + WD_W'(1);
                        end
                    end
                end
                S_PAUSE, S_JAM: begin
                    if (flip_working) begin
                        state_d = S_RUN;
                        wd_d    = '0;
                    end
                end
                S_DONE: begin
                    if (flip_working) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pill_q   <= '0;
            bottle_q <= '0;
            total_q  <= '0;
            spill_q  <= '0;
            pset_q   <= '0;
            bset_q   <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            pill_q   <= pill_d;
            bottle_q <= bottle_d;
            total_q  <= total_d;
            spill_q  <= spill_d;
            pset_q   <= pset_d;
            bset_q   <= bset_d;
            wd_q     <= wd_d;
        end
    end

    assign pill_current   = pill_q;
    assign bottle_current = bottle_q;
    assign total_current  = total_q;
    assign spill_count    = spill_q;
    assign state          = state_q;
    assign working        = (state_q == S_RUN);
    assign finished       = (state_q == S_DONE);
    assign jam            = (state_q == S_JAM);
    assign beep           = (finished | jam) & display_flicker;

endmodule

// File: tb/tb_bottling_core_mf.sv
// Directed bench for bottling_core_mf: a behavioural model compared every cycle,
// plus literal expectations at the interesting points.
module tb_bottling_core_mf;

    localparam int NF = 2;
    localparam int CW = 8;
    localparam int TW = 16;
    localparam int JC = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          display_flicker;
    logic [NF-1:0] pill_pulse;
    logic          flip_working;
    logic          abort;
    logic [CW-1:0] bottle_setting;
    logic [CW-1:0] pill_setting;
    logic [CW-1:0] pill_current;
    logic [CW-1:0] bottle_current;
    logic [TW-1:0] total_current;
    logic [CW-1:0] spill_count;
    logic [2:0]    state;
    logic          working;
    logic          finished;
    logic          jam;
    logic          beep;

    bottling_core_mf #(
        .NUM_FEEDERS(NF), .CNT_W(CW), .TOTAL_W(TW), .JAM_CYCLES(JC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .display_flicker(display_flicker),
        .pill_pulse(pill_pulse), .flip_working(flip_working), .abort(abort),
        .bottle_setting(bottle_setting), .pill_setting(pill_setting),
        .pill_current(pill_current), .bottle_current(bottle_current),
        .total_current(total_current), .spill_count(spill_count),
        .state(state), .working(working), .finished(finished), .jam(jam), .beep(beep)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: 0 IDLE, 1 RUN, 2 PAUSE, 3 JAM, 4 DONE
    int m_st, m_pill, m_bottle, m_total, m_spill, m_idle, m_pset, m_bset;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pill = 0; m_bottle = 0; m_total = 0;
        m_spill = 0; m_idle = 0; m_pset = 0; m_bset = 0;
    endtask

    task automatic model_step(input logic [NF-1:0] p, input logic f, input logic a);
        int n, rem;
        bit done_now;
        n = $countones(p);
        done_now = 0;
        if (a) begin
            m_st = 0; m_pill = 0; m_bottle = 0; m_total = 0; m_spill = 0; m_idle = 0;
        end else if (m_st == 0) begin
            if (f && bottle_setting != 0 && pill_setting != 0) begin
                m_st = 1; m_pset = pill_setting; m_bset = bottle_setting;
                m_pill = 0; m_bottle = 0; m_total = 0; m_spill = 0; m_idle = 0;
            end
        end else if (m_st == 1) begin
            if (n > 0) begin
                m_idle = 0;
                rem = m_pset - m_pill;
                if (n < rem) begin
                    m_pill += n;
                    m_total += n;
                end else begin
                    m_pill = 0;
                    m_bottle++;
                    m_total += rem;
                    m_spill = (m_spill + n - rem > 255) ? 255 : m_spill + n - rem;
                    done_now = (m_bottle == m_bset);
                end
            end
            if (done_now) m_st = 4;
            else if (f) m_st = 2;
            else if (n == 0) begin
                if (m_idle == JC - 1) m_st = 3;
                else m_idle++;
            end
        end else if (m_st == 2 || m_st == 3) begin
            if (f) begin m_st = 1; m_idle = 0; end
        end else begin
            if (f) m_st = 0;
        end
    endtask

    task automatic check_all();
        chk("state", 32'(state), m_st);
        chk("pill_current", 32'(pill_current), m_pill);
        chk("bottle_current", 32'(bottle_current), m_bottle);
        chk("total_current", 32'(total_current), m_total);
        chk("spill_count", 32'(spill_count), m_spill);
        chk("working", 32'(working), 32'(m_st == 1));
        chk("finished", 32'(finished), 32'(m_st == 4));
        chk("jam", 32'(jam), 32'(m_st == 3));
        chk("beep", 32'(beep), 32'((m_st == 3 || m_st == 4) && display_flicker));
    endtask

    task automatic step(input logic [NF-1:0] p, input logic f, input logic a);
        pill_pulse = p; flip_working = f; abort = a;
        model_step(p, f, a);
        @(posedge clk);
        #1;
        pill_pulse = '0; flip_working = 1'b0; abort = 1'b0;
        display_flicker = ~display_flicker;
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_pill[6] = '{1, 2, 0, 1, 2, 0};
        int exp_bot[6]  = '{0, 0, 1, 1, 1, 2};
        reset_n = 1'b0; display_flicker = 1'b0; pill_pulse = '0;
        flip_working = 1'b0; abort = 1'b0;
        bottle_setting = 8'd2; pill_setting = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_state_lit", 32'(state), 0);
        reset_n = 1'b1;

        // Start with a zero setting is ignored
        step(2'b00, 1'b1, 1'b0);
        chk("zero_pill_set_idle", 32'(state), 0);
        bottle_setting = 8'd0; pill_setting = 8'd3;
        step(2'b00, 1'b1, 1'b0);
        chk("zero_bottle_set_idle", 32'(state), 0);

        // Six single-feeder pulses fill two bottles of three
        bottle_setting = 8'd2;
        step(2'b00, 1'b1, 1'b0);
        chk("start_run", 32'(working), 1);
        for (int i = 0; i < 6; i++) begin
            step((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0);
            chk("seq_pill", 32'(pill_current), exp_pill[i]);
            chk("seq_bottle", 32'(bottle_current), exp_bot[i]);
        end
        chk("seq_finished", 32'(finished), 1);
        chk("seq_total", 32'(total_current), 6);
        chk("seq_spill", 32'(spill_count), 0);

        // DONE -> IDLE keeps counts, then a fresh start clears them
        step(2'b00, 1'b1, 1'b0);
        chk("done_idle_hold", 32'(total_current), 6);
        step(2'b00, 1'b1, 1'b0);
        chk("restart_clear", 32'(total_current), 0);

        // Overflow: two pills in, then both feeders fire
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        chk("ovf_bottle", 32'(bottle_current), 1);
        chk("ovf_pill", 32'(pill_current), 0);
        chk("ovf_total", 32'(total_current), 3);
        chk("ovf_spill", 32'(spill_count), 1);

        // Pause with a pulse in the flip cycle, then ignored pulses and a setting change
        step(2'b01, 1'b1, 1'b0);
        chk("pause_counted", 32'(pill_current), 1);
        chk("pause_state", 32'(state), 2);
        pill_setting = 8'd5;
        step(2'b11, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        chk("pause_frozen", 32'(total_current), 4);
        step(2'b00, 1'b1, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        chk("resume_latched_set", 32'(finished), 1);
        chk("resume_total", 32'(total_current), 6);

        // Watchdog
        pill_setting = 8'd3;
        step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(2'b00, 1'b0, 1'b0);
        chk("jam_not_yet", 32'(state), 1);
        step(2'b00, 1'b0, 1'b0);
        chk("jam_at_10", 32'(jam), 1);
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 1'b0, 1'b0);
            chk("jam_beep", 32'(beep), 32'(display_flicker));
        end
        step(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(2'b00, 1'b0, 1'b0);
        chk("wd_restart", 32'(state), 1);
        step(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        chk("flip_beats_jam", 32'(state), 2);
        step(2'b00, 1'b1, 1'b0);

        // Abort together with a pulse
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b1);
        chk("abort_state", 32'(state), 0);
        chk("abort_pill", 32'(pill_current), 0);
        chk("abort_total", 32'(total_current), 0);
        chk("abort_spill", 32'(spill_count), 0);

        // Asynchronous reset while DONE
        bottle_setting = 8'd1; pill_setting = 8'd1;
        step(2'b00, 1'b1, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        chk("done_single", 32'(finished), 1);
        chk("done_single_spill", 32'(spill_count), 1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_reset_total", 32'(total_current), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bottling_core_mf.md
Name: bottling_core_mf

Overview:
- Parametrised next-generation bottling core.
- Counts pills from NUM_FEEDERS parallel feeder pulse lines into bottles against settings latched at start.
- Adds pause/resume, abort, feeder-jam watchdog and overflow (spill) accounting.
- Sits between the input debounce/pulse logic and the display controller; exports counts, status and beep.

Parameters:
- NUM_FEEDERS, 2, number of pill pulse inputs, 1..8.
- CNT_W, 8, width of pill/bottle settings and per-bottle/bottle counters.
- TOTAL_W, 16, width of total pill counter; must be >= 2*CNT_W.
- JAM_CYCLES, 1000, RUN cycles with no pill pulse before JAM; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- display_flicker  in  1  blink reference for beep gating
- pill_pulse  in  NUM_FEEDERS  one-cycle pill pulses, one bit per feeder
- flip_working  in  1  one-cycle command: start/pause/resume/acknowledge
- abort  in  1  one-cycle command: return to IDLE, clear counters
- bottle_setting  in  CNT_W  target bottle count
- pill_setting  in  CNT_W  pills per bottle
- pill_current  out  CNT_W  pills in current bottle
- bottle_current  out  CNT_W  completed bottles
- total_current  out  TOTAL_W  pills actually bottled
- spill_count  out  CNT_W  pills discarded as overflow, saturating
- state  out  3  IDLE=0, RUN=1, PAUSE=2, JAM=3, DONE=4
- working  out  1  state==RUN
- finished  out  1  state==DONE
- jam  out  1  state==JAM
- beep  out  1  (finished|jam) & display_flicker, combinational

Behaviour:
- Reset: state=IDLE, all counters and latched settings 0, working/finished/jam=0.
- All state and counter updates happen on the rising clk edge and are visible the cycle after the sampled input.
- abort has priority over everything: any state -> IDLE; counters, spill and watchdog cleared on the same edge.

State transitions on flip_working (when abort=0):
- IDLE -> RUN only if bottle_setting!=0 and pill_setting!=0. Settings are latched and counters/watchdog cleared on that edge. With either setting 0, flip is ignored.
- RUN -> PAUSE: counters hold.
- PAUSE -> RUN: watchdog cleared.
- JAM -> RUN: watchdog cleared.
- DONE -> IDLE: counters hold until the next start.

Counting:
- Counting occurs only in RUN.
- n = popcount(pill_pulse); rem = pill_set - pill_current.
- If n < rem: pill_current += n; total += n.
- If n >= rem: bottle completes. pill_current <- 0; bottle_current += 1; total += rem; spill += n - rem, saturating at all-ones.
- Excess pills are never carried into the next bottle.
- If the completed bottle makes bottle_current == bottle_set, state -> DONE on the same edge. finished is visible with the final count.
- Pulses arriving in IDLE/PAUSE/JAM/DONE are ignored and are not counted as spill.
- Pulses arriving in the same cycle as flip_working in RUN are counted before the pause takes effect.

Watchdog:
- In RUN, a counter increments each cycle with n==0 and clears when n>0.
- When it reaches JAM_CYCLES-1 with n==0, state -> JAM.
- Completion in the same cycle wins over JAM.
- flip_working in the same cycle as the timeout edge wins over JAM: state -> PAUSE.

Settings: bottle_setting/pill_setting changes after start have no effect until the next IDLE->RUN.

Test Plan:
- NUM_FEEDERS=2, pill_set=3, bottle_set=2; single-feeder pulses 6 times -> pill counts 1,2,0; bottle 1 then 2; finished=1 on the 6th pulse edge; total=6, spill=0.
- pill_set=3 with pill_current=2; pulse both feeders -> bottle+1, pill_current=0, total+1, spill=1.
- JAM_CYCLES=10 in RUN with no pulses -> jam=1 at the 10th cycle; beep follows display_flicker; flip -> RUN and watchdog restarts.
- Flip in RUN -> PAUSE; pulses ignored; counters frozen. Flip -> RUN and counting resumes from the held values. Change pill_setting while paused -> no effect.
- abort asserted mid-RUN together with a pill pulse -> IDLE next cycle, all counters 0, the pulse is not counted.
- flip with pill_setting=0 in IDLE -> stays IDLE. Reset asserted asynchronously in DONE -> all outputs 0 immediately.
